rx_stream_decoder: RTL and testbench

// - Parametrised serial-to-symbol receive decoder for the Simple Encoding link.
// - Hunts for a sync word at any bit offset and locks symbol alignment.
// - Checks and decodes each marker/payload/parity/stop symbol.
// - Delivers payloads through a small FIFO with a valid/ready handshake, and drops lock after repeated errors.
// - Sits between the line bit sampler and the RX payload consumer.

---
 rtl/rx_enc_pkg.sv | 19 +
 rtl/rx_sym_fifo.sv | 46 ++++
 rtl/rx_stream_decoder.sv | 121 ++++++++++++
 tb/tb_rx_stream_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_enc_pkg.sv
// Shared types and helpers for the Simple Encoding receive path.
package rx_enc_pkg;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} rx_state_e;

  localparam logic [9:0] SYNC_DEF = 10'b1111100000;

  localparam int STOP_IDX = 0;
  localparam int PAR_IDX  = 1;

  function automatic logic odd_par(input logic [31:0] v);
    return ^v;
  endfunction

  function automatic int marker_idx(input int sym_w);
    return sym_w - 1;
  endfunction

endpackage

// File: rtl/rx_sym_fifo.sv
// Small synchronous FIFO; a push while full is taken when a pop lands on the same edge.
module rx_sym_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so dout is clean after reset.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/rx_stream_decoder.sv
// Serial symbol receiver: sync hunt, per-symbol check/decode, payload FIFO.
module rx_stream_decoder
  import rx_enc_pkg::*;
#(
  parameter int               SYM_W      = 10,
  parameter logic [SYM_W-1:0] SYNC_WORD  = SYNC_DEF,
  parameter int               MAX_ERR    = 4,
  parameter int               FIFO_DEPTH = 4,
  localparam int              DATA_W     = SYM_W - 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_in,
  input  logic              ser_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              locked,
  output logic              sym_err,
  output logic              overflow
);
  localparam int FW = $clog2(SYM_W + 1);
  localparam int BW = $clog2(SYM_W);
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(SYM_W);
  localparam logic [FW-1:0] FILL_LOCK = FW'(SYM_W - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(SYM_W - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(MAX_ERR - 1);

  rx_state_e         state, state_n;
  logic [SYM_W-2:0]  sr;
  logic [SYM_W-1:0]  win;
  logic [FW-1:0]     fill, fill_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic [EW-1:0]     errcnt, errcnt_n;
  logic              push, err_n, good, full, empty, pop;

  // Only the low SYM_W-1 history bits are ever observed, so that is all we keep.
  assign win  = {sr, ser_in};
  assign good = ~win[marker_idx(SYM_W)] & win[STOP_IDX]
              & odd_par(32'(win[SYM_W-2:PAR_IDX]));

  assign locked     = (state == LOCKED);
  assign dout_valid = ~empty;
  assign pop        = dout_valid & dout_ready;

  always_comb begin
    state_n  = state;
    fill_n   = fill;
    bitcnt_n = bitcnt;
    errcnt_n = errcnt;
    push     = 1'b0;
    err_n    = 1'b0;
    if (ser_valid) begin
      case (state)
        HUNT: begin
          if (fill != FILL_MAX) fill_n = fill + 1'b1;
          if (fill >= FILL_LOCK && win == SYNC_WORD) begin
            state_n  = LOCKED;
            bitcnt_n = '0;
            errcnt_n = '0;
          end
        end
        LOCKED: begin
          bitcnt_n = bitcnt + 1'b1;
          if (bitcnt == BIT_LAST) begin
            bitcnt_n = '0;
            if (win == SYNC_WORD) begin
              errcnt_n = '0;
            end else if (good) begin
              push     = 1'b1;
              errcnt_n = '0;
            end else begin
              err_n = 1'b1;
              if (errcnt == ERR_LAST) begin
                state_n  = HUNT;
                fill_n   = '0;
                errcnt_n = '0;
              end else begin
                errcnt_n = errcnt + 1'b1;
              end
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      sr       <= '0;
      fill     <= '0;
      bitcnt   <= '0;
      errcnt   <= '0;
      sym_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_n;
      fill    <= fill_n;
      bitcnt  <= bitcnt_n;
      errcnt  <= errcnt_n;
      sym_err <= err_n;
      if (ser_valid) sr <= win[SYM_W-2:0];
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  rx_sym_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (win[SYM_W-2:2]),
    .pop   (pop),
    .rdata (dout),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_rx_stream_decoder.sv
// Directed bench for rx_stream_decoder: vector table plus multi-cycle corner sequences.
module tb_rx_stream_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       dout_ready = 1'b0;
  logic [6:0] dout;
  logic       dout_valid, locked, sym_err, overflow;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [9:0] SYNC = 10'b1111100000;

  typedef struct {
    logic [9:0] sym;
    logic       push;
    logic [6:0] dout;
    logic       err;
  } vec_t;

  vec_t       tbl[14];
  logic [9:0] gsym[5];
  logic [6:0] gpay[5];

  rx_stream_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .locked     (locked),
    .sym_err    (sym_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    ser_in     = b;
    ser_valid  = 1'b1;
    dout_ready = rdy;
    @(posedge clk); #1;
    ser_valid  = 1'b0;
    dout_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    repeat (n) begin
      ser_in = ~ser_in;
      @(posedge clk);
    end
    #1;
  endtask

  // gap_at: bit index before which three idle cycles are inserted (-1 for none).
  task automatic send_sym(input logic [9:0] s, input logic rdy_last, input int gap_at);
    for (int i = 9; i >= 0; i--) begin
      if (i == gap_at) idle(3);
      send_bit(s[i], (i == 0) ? rdy_last : 1'b0);
    end
  endtask

  task automatic pop_one();
    dout_ready = 1'b1;
    ser_valid  = 1'b0;
    @(posedge clk); #1;
    dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; ser_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{10'b0101010111, 1'b1, 7'h55, 1'b0};
    tbl[1]  = '{10'b0000000011, 1'b1, 7'h00, 1'b0};
    tbl[2]  = '{10'b0111111101, 1'b1, 7'h7f, 1'b0};
    tbl[3]  = '{10'b0000000101, 1'b1, 7'h01, 1'b0};
    tbl[4]  = '{10'b1000000011, 1'b0, 7'h00, 1'b1};
    tbl[5]  = '{10'b0101010110, 1'b0, 7'h00, 1'b1};
    tbl[6]  = '{10'b0101010101, 1'b0, 7'h00, 1'b1};
    tbl[7]  = '{10'b0110011011, 1'b1, 7'h66, 1'b0};
    tbl[8]  = '{10'b0000000001, 1'b0, 7'h00, 1'b1};
    tbl[9]  = '{SYNC,           1'b0, 7'h00, 1'b0};
    tbl[10] = '{10'b0101010101, 1'b0, 7'h00, 1'b1};
    tbl[11] = '{10'b0101010101, 1'b0, 7'h00, 1'b1};
    tbl[12] = '{10'b0101010101, 1'b0, 7'h00, 1'b1};
    tbl[13] = '{10'b0010000001, 1'b1, 7'h20, 1'b0};
    for (int i = 0; i < 5; i++) begin
      gsym[i] = tbl[(i < 4) ? i : 7].sym;
      gpay[i] = tbl[(i < 4) ? i : 7].dout;
    end

    // Reset state
    do_reset();
    chk("rst_locked", locked, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_symerr", sym_err, 0);
    chk("rst_ovf", overflow, 0);

    // 1: zeros, aligned sync, one good symbol
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0);
    for (int i = 9; i >= 1; i--) send_bit(SYNC[i], 1'b0);
    chk("t1_prelock", locked, 0);
    send_bit(SYNC[0], 1'b0);
    chk("t1_locked", locked, 1);
    send_sym(10'b0101010111, 1'b0, -1);
    chk("t1_valid", dout_valid, 1);
    chk("t1_dout", dout, 7'h55);
    pop_one();
    chk("t1_drained", dout_valid, 0);

    // Table: good/bad/sync symbols while locked, each followed by a pop cycle
    for (int i = 0; i < 14; i++) begin
      send_sym(tbl[i].sym, 1'b0, -1);
      chk($sformatf("tbl%0d_valid", i), dout_valid, tbl[i].push);
      if (tbl[i].push) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].dout);
      chk($sformatf("tbl%0d_err", i), sym_err, tbl[i].err);
      chk($sformatf("tbl%0d_locked", i), locked, 1);
      pop_one();
      chk($sformatf("tbl%0d_empty", i), dout_valid, 0);
      chk($sformatf("tbl%0d_errpulse", i), sym_err, 0);
    end

    // 2: junk 101, unaligned sync, symbol with an idle gap mid-way
    do_reset();
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_sym(SYNC, 1'b0, -1);
    chk("t2_locked", locked, 1);
    send_sym(10'b0000000011, 1'b0, 5);
    chk("t2_valid", dout_valid, 1);
    chk("t2_dout", dout, 7'h00);
    pop_one();

    // 3: four bad-parity symbols drop lock, then no data without sync
    for (int k = 0; k < 4; k++) begin
      send_sym(10'b0101010101, 1'b0, -1);
      chk($sformatf("t3_err%0d", k), sym_err, 1);
      chk($sformatf("t3_locked%0d", k), locked, (k < 3) ? 1 : 0);
    end
    for (int k = 0; k < 3; k++) begin
      send_sym(10'b0101010111, 1'b0, -1);
      chk($sformatf("t3_hunt_valid%0d", k), dout_valid, 0);
      chk($sformatf("t3_hunt_err%0d", k), sym_err, 0);
      chk($sformatf("t3_hunt_locked%0d", k), locked, 0);
    end

    // 4: five goods into a 4-deep FIFO with no consumer
    do_reset();
    send_sym(SYNC, 1'b0, -1);
    for (int k = 0; k < 5; k++) begin
      send_sym(gsym[k], 1'b0, -1);
      chk($sformatf("t4_ovf%0d", k), overflow, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_valid%0d", k), dout_valid, 1);
      chk($sformatf("t4_dout%0d", k), dout, gpay[k]);
      pop_one();
    end
    chk("t4_empty", dout_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // 5: full FIFO, pop on the same edge that completes a good symbol
    do_reset();
    send_sym(SYNC, 1'b0, -1);
    for (int k = 0; k < 4; k++) send_sym(gsym[k], 1'b0, -1);
    send_sym(gsym[4], 1'b1, -1);
    chk("t5_ovf", overflow, 0);
    for (int k = 1; k < 5; k++) begin
      chk($sformatf("t5_dout%0d", k), dout, gpay[k]);
      pop_one();
    end
    chk("t5_empty", dout_valid, 0);

    // 6: reset mid-symbol while locked with two entries queued
    do_reset();
    send_sym(SYNC, 1'b0, -1);
    send_sym(gsym[0], 1'b0, -1);
    send_sym(gsym[1], 1'b0, -1);
    for (int i = 9; i >= 6; i--) send_bit(gsym[2][i], 1'b0);
    chk("t6_pre_valid", dout_valid, 1);
    rst = 1'b1; ser_in = 1'b1; ser_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ser_valid = 1'b0;
    chk("t6_locked", locked, 0);
    chk("t6_valid", dout_valid, 0);
    chk("t6_ovf", overflow, 0);
    send_sym(SYNC, 1'b0, -1);
    chk("t6_relock", locked, 1);
    send_sym(gsym[3], 1'b0, -1);
    chk("t6_dout", dout, gpay[3]);
    chk("t6_dvalid", dout_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
